// File: rtl/aes_encrypt_iter.sv
// Iterative AES encryptor (128/192/256-bit keys): one round per clock on a shared
// round datapath, with the whole expanded key schedule held so one key load serves many blocks.
module aes_encrypt_iter #(
    parameter int KEY_SIZE = 128
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                key_valid,
    output logic                key_ready,
    input  logic [KEY_SIZE-1:0] key,
    output logic                key_loaded,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [127:0]        in_data,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [127:0]        out_data
);
    localparam int NK   = KEY_SIZE / 32;
    localparam int NR   = NK + 6;
    localparam int NW   = 4 * (NR + 1);
    localparam int IDXW = $clog2(NW);
    localparam int RW   = $clog2(NR + 2);
    localparam int KW   = $clog2(NK);

    if (KEY_SIZE != 128 && KEY_SIZE != 192 && KEY_SIZE != 256) begin : g_bad_key_size
        $error("aes_encrypt_iter: KEY_SIZE must be 128, 192 or 256");
    end

    localparam logic [0:255][7:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX[b];
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [31:0] subWord(input logic [31:0] x);
        return {sbox(x[31:24]), sbox(x[23:16]), sbox(x[15:8]), sbox(x[7:0])};
    endfunction

    // State byte b sits at [127-8b -: 8] with b = row + 4*column.
    function automatic logic [127:0] subShift(input logic [127:0] s);
        logic [127:0] r;
        r = '0;
        for (int c = 0; c < 4; c++) begin
            for (int row = 0; row < 4; row++) begin
                r[127-8*(row+4*c) -: 8] = sbox(s[127-8*(row+4*((c+row)%4)) -: 8]);
            end
        end
        return r;
    endfunction

    function automatic logic [127:0] mixColumns(input logic [127:0] s);
        logic [127:0] r;
        logic [7:0]   a0, a1, a2, a3;
        r = '0;
        for (int c = 0; c < 4; c++) begin
            a0 = s[127-32*c -: 8];
            a1 = s[119-32*c -: 8];
            a2 = s[111-32*c -: 8];
            a3 = s[103-32*c -: 8];
            r[127-32*c -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
            r[119-32*c -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
            r[111-32*c -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
            r[103-32*c -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
        end
        return r;
    endfunction

    typedef enum logic [1:0] {IDLE, KEXP, ROUND, DONE} state_e;

    state_e          fsm_q;
    logic [127:0]    block_q;
    logic [RW-1:0]   round_q;
    logic [IDXW-1:0] wordIdx_q;
    logic [KW-1:0]   wordMod_q;
    logic [7:0]      rcon_q;
    logic            keyLoaded_q;
    logic            outValid_q;
    logic [127:0]    outData_q;
    logic [31:0]     w_q [NW];

    logic            keyFire;
    logic            blockFire;
    logic [31:0]     prevWord;
    logic [31:0]     expWord_d;
    logic [IDXW-1:0] rkBase;
    logic [127:0]    roundKey;
    logic [127:0]    subShifted;
    logic [127:0]    roundOut_d;

    assign key_ready  = (fsm_q == IDLE);
    assign in_ready   = (fsm_q == IDLE) && keyLoaded_q && !key_valid;
    assign keyFire    = key_valid && key_ready;
    assign blockFire  = in_valid && in_ready;
    assign key_loaded = keyLoaded_q;
    assign out_valid  = outValid_q;
    assign out_data   = outData_q;

    // wordMod_q tracks i mod NK so no divider is needed for the 192-bit schedule.
    always_comb begin
        prevWord = w_q[wordIdx_q - IDXW'(1)];
        if (wordMod_q == '0) begin
            expWord_d = subWord({prevWord[23:0], prevWord[31:24]}) ^ {rcon_q, 24'h000000};
        end else if (NK == 8 && int'(wordMod_q) == 4) begin
            expWord_d = subWord(prevWord);
        end else begin
            expWord_d = prevWord;
        end
        expWord_d = expWord_d ^ w_q[wordIdx_q - IDXW'(NK)];
    end

    always_comb begin
        rkBase     = IDXW'({round_q, 2'b00});
        roundKey   = {w_q[rkBase], w_q[rkBase + IDXW'(1)],
                      w_q[rkBase + IDXW'(2)], w_q[rkBase + IDXW'(3)]};
        subShifted = subShift(block_q);
        roundOut_d = ((round_q == RW'(NR)) ? subShifted : mixColumns(subShifted)) ^ roundKey;
    end

    // Key schedule store needs no reset: key_loaded guards every read of it.
    for (genvar g = 0; g < NW; g++) begin : g_word
        if (g < NK) begin : g_key
            always_ff @(posedge clk) begin
                if (keyFire) w_q[g] <= key[KEY_SIZE-1-32*g -: 32];
            end
        end else begin : g_exp
            always_ff @(posedge clk) begin
                if (fsm_q == KEXP && wordIdx_q == IDXW'(g)) w_q[g] <= expWord_d;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm_q       <= IDLE;
            block_q     <= '0;
            round_q     <= '0;
            wordIdx_q   <= '0;
            wordMod_q   <= '0;
            rcon_q      <= 8'h01;
            keyLoaded_q <= 1'b0;
            outValid_q  <= 1'b0;
            outData_q   <= '0;
        end else begin
            case (fsm_q)
                IDLE: begin
                    if (keyFire) begin
                        fsm_q       <= KEXP;
                        keyLoaded_q <= 1'b0;
                        wordIdx_q   <= IDXW'(NK);
                        wordMod_q   <= '0;
                        rcon_q      <= 8'h01;
                    end else if (blockFire) begin
                        fsm_q   <= ROUND;
                        block_q <= in_data ^ {w_q[0], w_q[1], w_q[2], w_q[3]};
                        round_q <= RW'(1);
                    end
                end
                KEXP: begin
                    wordIdx_q <= wordIdx_q + IDXW'(1);
                    wordMod_q <= (int'(wordMod_q) == NK - 1) ? '0 : wordMod_q + KW'(1);
                    if (wordMod_q == '0) rcon_q <= xtime(rcon_q);
                    if (int'(wordIdx_q) == NW - 1) begin
                        keyLoaded_q <= 1'b1;
                        fsm_q       <= IDLE;
                    end
                end
                ROUND: begin
                    block_q <= roundOut_d;
                    round_q <= round_q + RW'(1);
                    if (round_q == RW'(NR)) begin
                        outData_q  <= roundOut_d;
                        outValid_q <= 1'b1;
                        fsm_q      <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        outValid_q <= 1'b0;
                        fsm_q      <= IDLE;
                    end
                end
                default: fsm_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_aes_encrypt_iter.sv
// Directed bench for aes_encrypt_iter: FIPS-197 vectors for all three key sizes,
// handshake timing, backpressure, key/plaintext priority and reset mid-round.
module tb_aes_encrypt_iter;
    localparam logic [255:0] KEY_B   = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
    localparam logic [127:0] PT_B    = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] CT_B    = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [255:0] KEY_C1  = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
    localparam logic [255:0] KEY_C2  = {192'h000102030405060708090a0b0c0d0e0f1011121314151617, 64'h0};
    localparam logic [255:0] KEY_C3  = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    localparam logic [127:0] PT_C    = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CT_C1   = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] CT_C2   = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
    localparam logic [127:0] CT_C3   = 128'h8ea2b7ca516745bfeafc49904b496089;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [2:0]   kValid;
    logic [2:0]   iValid;
    logic [2:0]   oReady;
    logic [255:0] keyIn;
    logic [127:0] ptIn;
    wire  [2:0]   kReady;
    wire  [2:0]   kLoaded;
    wire  [2:0]   iReady;
    wire  [2:0]   oValid;
    wire  [127:0] ctOut [3];
    int           nAssert = 0;
    int           nFail = 0;
    int           cyc = 0;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    aes_encrypt_iter #(.KEY_SIZE(128)) dut128 (
        .clk(clk), .rst_n(rst_n), .key_valid(kValid[0]), .key_ready(kReady[0]),
        .key(keyIn[255:128]), .key_loaded(kLoaded[0]), .in_valid(iValid[0]),
        .in_ready(iReady[0]), .in_data(ptIn), .out_valid(oValid[0]),
        .out_ready(oReady[0]), .out_data(ctOut[0])
    );

    aes_encrypt_iter #(.KEY_SIZE(192)) dut192 (
        .clk(clk), .rst_n(rst_n), .key_valid(kValid[1]), .key_ready(kReady[1]),
        .key(keyIn[255:64]), .key_loaded(kLoaded[1]), .in_valid(iValid[1]),
        .in_ready(iReady[1]), .in_data(ptIn), .out_valid(oValid[1]),
        .out_ready(oReady[1]), .out_data(ctOut[1])
    );

    aes_encrypt_iter #(.KEY_SIZE(256)) dut256 (
        .clk(clk), .rst_n(rst_n), .key_valid(kValid[2]), .key_ready(kReady[2]),
        .key(keyIn), .key_loaded(kLoaded[2]), .in_valid(iValid[2]),
        .in_ready(iReady[2]), .in_data(ptIn), .out_valid(oValid[2]),
        .out_ready(oReady[2]), .out_data(ctOut[2])
    );

    task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        nAssert++;
        assert (obs === exp) else begin
            nFail++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Offers are driven one step after a rising edge and left to settle before sampling.
    task automatic applyStimulus(input int sel, input logic offerKey, input logic offerBlock,
                                 input logic [255:0] keyVal, input logic [127:0] ptVal);
        keyIn        = keyVal;
        ptIn         = ptVal;
        kValid[sel]  = offerKey;
        iValid[sel]  = offerBlock;
        #1;
    endtask

    task automatic clockAndRelease(input int sel);
        @(posedge clk);
        #1;
        kValid[sel] = 1'b0;
        iValid[sel] = 1'b0;
    endtask

    task automatic waitKeyLoaded(input int sel, input int expCycles);
        int cnt = 0;
        while (kLoaded[sel] !== 1'b1 && cnt < 200) begin
            @(posedge clk);
            #1;
            cnt++;
        end
        checkOutput("key expansion cycles", cnt, expCycles);
    endtask

    task automatic loadKey(input int sel, input logic [255:0] keyVal, input int expCycles);
        applyStimulus(sel, 1'b1, 1'b0, keyVal, '0);
        checkOutput("key_ready in IDLE", kReady[sel], 1'b1);
        clockAndRelease(sel);
        waitKeyLoaded(sel, expCycles);
    endtask

    task automatic startBlock(input int sel, input logic [127:0] ptVal);
        applyStimulus(sel, 1'b0, 1'b1, '0, ptVal);
        checkOutput("in_ready before block", iReady[sel], 1'b1);
        clockAndRelease(sel);
    endtask

    task automatic waitOutput(input int sel, input int expLatency, input logic [127:0] expCt);
        int cnt = 0;
        while (oValid[sel] !== 1'b1 && cnt < 100) begin
            @(posedge clk);
            #1;
            cnt++;
        end
        checkOutput("block latency", cnt, expLatency);
        checkOutput("ciphertext", ctOut[sel], expCt);
    endtask

    task automatic consume(input int sel);
        oReady[sel] = 1'b1;
        @(posedge clk);
        #1;
        oReady[sel] = 1'b0;
        checkOutput("out_valid after transfer", oValid[sel], 1'b0);
    endtask

    initial begin
        int firstCyc;
        int secondCyc;

        rst_n  = 1'b0;
        kValid = '0;
        iValid = '0;
        oReady = '0;
        keyIn  = '0;
        ptIn   = '0;
        #1;
        checkOutput("reset key_loaded", kLoaded, 3'b000);
        checkOutput("reset out_valid", oValid, 3'b000);
        checkOutput("reset out_data", ctOut[0], 128'h0);
        checkOutput("reset key_ready", kReady, 3'b111);
        checkOutput("reset in_ready", iReady, 3'b000);
        #12;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        $display("[TB] plaintext offered before any key");
        iValid[0] = 1'b1;
        ptIn      = PT_B;
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        checkOutput("no block without key", {oValid[0], iReady[0], kReady[0]}, 3'b001);
        iValid[0] = 1'b0;

        $display("[TB] AES-128 FIPS-197 appendix B");
        loadKey(0, KEY_B, 40);
        startBlock(0, PT_B);
        waitOutput(0, 10, CT_B);
        consume(0);

        $display("[TB] backpressure");
        startBlock(0, PT_B);
        waitOutput(0, 10, CT_B);
        ptIn      = PT_C;
        iValid[0] = 1'b1;
        for (int k = 0; k < 20; k++) begin
            @(posedge clk);
            #1;
            checkOutput("held out_data", ctOut[0], CT_B);
            checkOutput("held out_valid/in_ready", {oValid[0], iReady[0]}, 2'b10);
        end
        iValid[0] = 1'b0;
        consume(0);
        checkOutput("in_ready after transfer", iReady[0], 1'b1);
        checkOutput("out_data kept after transfer", ctOut[0], CT_B);

        $display("[TB] back-to-back blocks");
        ptIn      = PT_B;
        iValid[0] = 1'b1;
        oReady[0] = 1'b1;
        firstCyc  = -1;
        secondCyc = -1;
        for (int k = 0; k < 60 && secondCyc < 0; k++) begin
            @(posedge clk);
            #1;
            if (oValid[0] === 1'b1) begin
                checkOutput("back-to-back ciphertext", ctOut[0], CT_B);
                if (firstCyc < 0) firstCyc = cyc;
                else secondCyc = cyc;
            end
        end
        iValid[0] = 1'b0;
        checkOutput("back-to-back spacing", secondCyc - firstCyc, 12);
        @(posedge clk);
        #1;
        oReady[0] = 1'b0;
        checkOutput("idle after back-to-back", {oValid[0], iReady[0]}, 2'b01);

        $display("[TB] key offer beats plaintext offer");
        applyStimulus(0, 1'b1, 1'b1, KEY_C1, PT_C);
        checkOutput("in_ready under key offer", iReady[0], 1'b0);
        checkOutput("key_ready under key offer", kReady[0], 1'b1);
        clockAndRelease(0);
        checkOutput("key_loaded cleared on reload", kLoaded[0], 1'b0);
        checkOutput("in_ready during expansion", iReady[0], 1'b0);
        waitKeyLoaded(0, 40);
        checkOutput("no block taken with key", oValid[0], 1'b0);
        startBlock(0, PT_C);
        waitOutput(0, 10, CT_C1);
        consume(0);

        $display("[TB] AES-192 and AES-256");
        loadKey(1, KEY_C2, 46);
        startBlock(1, PT_C);
        waitOutput(1, 12, CT_C2);
        consume(1);
        loadKey(2, KEY_C3, 52);
        startBlock(2, PT_C);
        waitOutput(2, 14, CT_C3);
        consume(2);

        $display("[TB] reset during round 5");
        startBlock(0, PT_C);
        repeat (4) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        checkOutput("reset mid-round out_valid", oValid[0], 1'b0);
        checkOutput("reset mid-round key_loaded", kLoaded, 3'b000);
        checkOutput("reset mid-round key_ready", kReady[0], 1'b1);
        #3;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        iValid[0] = 1'b1;
        ptIn      = PT_C;
        repeat (5) begin
            @(posedge clk);
            #1;
        end
        checkOutput("no block after reset", {oValid[0], iReady[0]}, 2'b00);
        iValid[0] = 1'b0;
        loadKey(0, KEY_C1, 40);
        startBlock(0, PT_C);
        waitOutput(0, 10, CT_C1);
        consume(0);

        $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: run did not complete, observed timeout expected finish");
        $fatal(1, "[TB] watchdog timeout");
    end

endmodule
